operation_s_seq: RTL

- Sequencer for the superposition (composition) operator S(f; g0..gN-1).
- Starts NARG inner operator blocks in parallel over their ST/RD handshake and latches each inner result as it completes.
- Then presents the collected results to one outer operator block, starts it, and returns its result.
- Sits between a parent caller and operator blocks that use the ST-rising-edge / RD handshake; multiple instances nest to build composite functions.

---
 rtl/operation_s_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/operation_s_seq.sv
// Sequencer for the superposition operator S(f; g0..gN-1): runs NARG inner operators in
// parallel, latches their results, then runs one outer operator on them and returns its result.
module operation_s_seq #(
    parameter int unsigned BW   = 16,
    parameter int unsigned NARG = 3,
    parameter int unsigned TMO  = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               st_i,
    output logic               rd_o,
    output logic [BW-1:0]      res_o,
    output logic               err_o,
    output logic [NARG-1:0]    ist_o,
    input  logic [NARG-1:0]    ird_i,
    input  logic [NARG*BW-1:0] ires_i,
    output logic               ost_o,
    input  logic               ord_i,
    input  logic [BW-1:0]      ores_i,
    output logic [NARG*BW-1:0] oarg_o
);

    localparam int unsigned CntW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {StIdle, StIWait, StOIssue, StOWait} state_e;

    state_e              state_q;
    logic                st_old_q;
    logic                armed_q;
    logic                rd_q;
    logic                err_q;
    logic [BW-1:0]       res_q;
    logic [NARG-1:0]     ist_q;
    logic                ost_q;
    logic [NARG*BW-1:0]  oarg_q;
    logic [NARG-1:0]     done_q;
    logic [NARG-1:0]     seen_low_q;
    logic                oseen_low_q;
    logic [CntW-1:0]     cnt_q;

    logic                start;
    logic [NARG-1:0]     inner_fire;
    logic [NARG-1:0]     done_all;
    logic                outer_fire;
    logic [CntW-1:0]     cnt_inc;
    logic                timeout;

    // A child's completion only counts after it has been seen busy, so a stale high RD is ignored.
    always_comb begin
        start      = st_i & ~st_old_q & armed_q;
        inner_fire = ird_i & seen_low_q & ~done_q;
        done_all   = done_q | inner_fire;
        outer_fire = ord_i & oseen_low_q;
        cnt_inc    = cnt_q + CntW'(1);
        timeout    = (TMO != 0) && (cnt_inc == CntW'(TMO));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            st_old_q    <= 1'b0;
            armed_q     <= 1'b0;
            rd_q        <= 1'b1;
            err_q       <= 1'b0;
            res_q       <= '0;
            ist_q       <= '0;
            ost_q       <= 1'b0;
            oarg_q      <= '0;
            done_q      <= '0;
            seen_low_q  <= '0;
            oseen_low_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            st_old_q <= st_i;
            // ST held high across reset release must go low once before it can start a run.
            if (!st_i) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rd_q        <= 1'b0;
                        err_q       <= 1'b0;
                        ist_q       <= '1;
                        done_q      <= '0;
                        seen_low_q  <= '0;
                        oseen_low_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StIWait;
                    end
                end
                StIWait: begin
                    ist_q <= '0;
                    cnt_q <= cnt_inc;
                    for (int unsigned k = 0; k < NARG; k++) begin
                        if (!ird_i[k]) begin
                            seen_low_q[k] <= 1'b1;
                        end
                        if (inner_fire[k]) begin
                            oarg_q[k*BW +: BW] <= ires_i[k*BW +: BW];
                            done_q[k]          <= 1'b1;
                        end
                    end
                    if (&done_all) begin
                        ost_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StOIssue;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StOIssue: begin
                    ost_q <= 1'b0;
                    cnt_q <= cnt_inc;
                    if (timeout) begin
                        err_q   <= 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StOWait;
                    end
                end
                StOWait: begin
                    cnt_q <= cnt_inc;
                    if (!ord_i) begin
                        oseen_low_q <= 1'b1;
                    end
                    if (outer_fire) begin
                        res_q   <= ores_i;
                        rd_q    <= 1'b1;
                        state_q <= StIdle;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_o   = rd_q;
    assign res_o  = res_q;
    assign err_o  = err_q;
    assign ist_o  = ist_q;
    assign ost_o  = ost_q;
    assign oarg_o = oarg_q;

endmodule
